// File: rtl/button_event_pkg.sv
// Shared definitions for the button front-end (debouncer and event classifier).
// Holds the classifier state type and the default timing constants derived
// from the system clock frequency.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned LONG_PRESS_MS = 1000;
    localparam int unsigned REPEAT_MS     = 200;

    // Converts a duration in milliseconds into system clock cycles.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned DEF_LONG_CYCLES   = ms_to_cycles(LONG_PRESS_MS);
    localparam int unsigned DEF_REPEAT_CYCLES = ms_to_cycles(REPEAT_MS);
    localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/button_event_sync_2ff.sv
// Two-stage synchroniser for a single asynchronous level.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two-flop capture of the asynchronous input level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/button_event.sv
// Button event classifier: resynchronises the debounced level and turns it
// into single-cycle press / short-release / long-press / auto-repeat pulses,
// plus a "held" level while a long press is in progress.
// Optional feature: define BUTTON_EVENT_REPEAT_EN to build the auto-repeat
// counter; when undefined, o_repeat is tied low and REPEAT_CYCLES is unused.
// Port note: the spec's "repeat" is an SV keyword, so data ports carry i_/o_
// prefixes (i_in, o_press, o_short_rel, o_long_press, o_repeat, o_held).
module button_event
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_press,
    output logic o_short_rel,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_held
);

    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);

    // Parameter legality is checked at elaboration.
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("button_event: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("button_event: REPEAT_CYCLES must be >= 2");
    end
    if ((64'(LONG_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cnt_long
        $error("button_event: CNT_W too narrow for LONG_CYCLES");
    end
    if ((64'(REPEAT_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cnt_rep
        $error("button_event: CNT_W too narrow for REPEAT_CYCLES");
    end

    logic             w_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_short_rel;
    logic             r_long_press;
    logic             r_held;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_in),
        .o_q (w_s2)
    );

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_M1 = CNT_W'(REPEAT_CYCLES - 1);
    logic r_repeat;
`endif

    // Classifier FSM with hold counter; every output is a registered pulse/level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_press      <= 1'b0;
            r_short_rel  <= 1'b0;
            r_long_press <= 1'b0;
            r_held       <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            r_repeat     <= 1'b0;
`endif
        end else begin
            r_press      <= 1'b0;
            r_short_rel  <= 1'b0;
            r_long_press <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            r_repeat     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_s2) begin
                        r_state <= PRESSED;
                        r_press <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it beats the long-press threshold.
                    if (!w_s2) begin
                        r_state     <= IDLE;
                        r_short_rel <= 1'b1;
                        r_cnt       <= '0;
                    end else if (r_cnt == LONG_M1) begin
                        r_state      <= HELD;
                        r_long_press <= 1'b1;
                        r_held       <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_s2) begin
                        r_state <= IDLE;
                        r_held  <= 1'b0;
                        r_cnt   <= '0;
                    end
`ifdef BUTTON_EVENT_REPEAT_EN
                    else if (r_cnt == REP_M1) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_held  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_press      = r_press;
    assign o_short_rel  = r_short_rel;
    assign o_long_press = r_long_press;
    assign o_held       = r_held;
`ifdef BUTTON_EVENT_REPEAT_EN
    assign o_repeat     = r_repeat;
`else
    assign o_repeat     = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Randomised scoreboard bench for button_event (LONG_CYCLES=8, REPEAT_CYCLES=4).
// A reference model derives expected events from hold duration arithmetic;
// a separate monitor pops expected events whenever the DUT pulses.
module tb_button_event;

    localparam int unsigned LONG = 8;
    localparam int unsigned REP  = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    // event codes ordered as {press, short_rel, long_press, repeat}
    localparam logic [3:0] EV_PRESS = 4'b1000;
    localparam logic [3:0] EV_SHORT = 4'b0100;
    localparam logic [3:0] EV_LONG  = 4'b0010;
    localparam logic [3:0] EV_REP   = 4'b0001;

    typedef struct {
        logic [3:0]  code;
        int unsigned cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_in = 1'b1;
    logic o_press, o_short_rel, o_long_press, o_repeat, o_held;

    int checks = 0;
    int errors = 0;

    ev_t exp_q[$];

    button_event #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .CNT_W         (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_in         (i_in),
        .o_press      (o_press),
        .o_short_rel  (o_short_rel),
        .o_long_press (o_long_press),
        .o_repeat     (o_repeat),
        .o_held       (o_held)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (runs on each rising edge) ----------------
    int unsigned n_edge    = 0;
    bit          started   = 1'b0;
    logic        d1        = 1'b0;  // input sampled one edge ago
    logic        d2        = 1'b0;  // input sampled two edges ago
    bit          m_pressed = 1'b0;
    int unsigned m_start   = 0;
    logic        exp_held  = 1'b0;
    logic        m_v;
    int unsigned m_h;

    always @(posedge clk) begin
        n_edge  = n_edge + 1;
        started = 1'b1;
        if (rst) begin
            d1        = 1'b0;
            d2        = 1'b0;
            m_pressed = 1'b0;
            exp_held  = 1'b0;
        end else begin
            m_v = d2;
            d2  = d1;
            d1  = i_in;
            if (!m_pressed) begin
                if (m_v) begin
                    m_pressed = 1'b1;
                    m_start   = n_edge;
                    exp_q.push_back('{EV_PRESS, n_edge});
                end
            end else begin
                m_h = n_edge - m_start;
                if (!m_v) begin
                    m_pressed = 1'b0;
                    exp_held  = 1'b0;
                    if (m_h <= LONG) exp_q.push_back('{EV_SHORT, n_edge});
                end else if (m_h == LONG) begin
                    exp_held = 1'b1;
                    exp_q.push_back('{EV_LONG, n_edge});
                end else if (REP_EN && m_h > LONG && ((m_h - LONG) % REP) == 0) begin
                    exp_q.push_back('{EV_REP, n_edge});
                end
            end
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    logic [3:0] got;
    ev_t        e;

    always @(negedge clk) begin
        if (started) begin
            got = {o_press, o_short_rel, o_long_press, o_repeat};
            while (exp_q.size() > 0 && exp_q[0].cyc < n_edge) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event code %b at edge %0d (now %0d)", e.code, e.cyc, n_edge);
            end
            if (got !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got %b want none at edge %0d", got, n_edge);
                end else begin
                    e = exp_q.pop_front();
                    if (e.code !== got || e.cyc != n_edge) begin
                        errors++;
                        $display("FAIL event got %b@%0d want %b@%0d", got, n_edge, e.code, e.cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == n_edge) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event got 0000 want %b at edge %0d", e.code, n_edge);
            end
            checks++;
            if (o_held !== exp_held) begin
                errors++;
                $display("FAIL held got %b want %b at edge %0d", o_held, exp_held, n_edge);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_for(input logic lvl, input int unsigned n);
        i_in = lvl;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({o_press, o_short_rel, o_long_press, o_repeat, o_held} !== 5'b0) begin
            errors++;
            $display("FAIL %s got %b want 00000", name,
                     {o_press, o_short_rel, o_long_press, o_repeat, o_held});
        end
    endtask

    // Releases rst (with i_in high) and expects press on the third falling edge.
    task automatic release_and_expect_press(input string name);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (o_press !== (i == 2)) begin
                errors++;
                $display("FAIL %s press at step %0d got %b want %b", name, i, o_press, (i == 2));
            end
        end
        #1;
    endtask

    initial begin
        // reset held with input high: nothing may come out
        rst  = 1'b1;
        i_in = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        release_and_expect_press("reset_release");

        // keep held: long press, repeats, then silent release
        drive_for(1'b1, 20);
        drive_for(1'b0, 8);

        // short press of 5 cycles
        drive_for(1'b1, 5);
        drive_for(1'b0, 8);

        // release lands exactly on the long-press threshold edge
        drive_for(1'b1, LONG);
        drive_for(1'b0, 8);

        // one edge longer: long press, then release
        drive_for(1'b1, LONG + 1);
        drive_for(1'b0, 8);

        // single-cycle pulse
        drive_for(1'b1, 1);
        drive_for(1'b0, 8);

        // reset in the middle of HELD
        drive_for(1'b1, 16);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_held");
        drive_for(1'b1, 2);
        release_and_expect_press("reset_mid_held_release");
        drive_for(1'b1, 30);
        drive_for(1'b0, 8);

        // randomised segments with occasional resets
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                drive_for(1'($urandom_range(0, 1)), $urandom_range(1, 3));
                rst = 1'b0;
            end
            drive_for(1'b1, $urandom_range(1, 30));
            drive_for(1'b0, $urandom_range(1, 12));
        end

        drive_for(1'b0, 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the majority-vote button debouncer and consumes its debounced level output.
- Resynchronises the level into the system clock domain and classifies it into single-cycle event pulses: press, short release, long press and (optionally) auto-repeat.
- Feeds menu/control logic that needs discrete events rather than a level.

Parameters:
- LONG_CYCLES, 50000000, hold time in clk cycles after which a press becomes a long press (1 s at 50 MHz); legal range ≥2.
- REPEAT_CYCLES, 10000000, auto-repeat period in clk cycles while held; legal range ≥2; used only with the optional feature.
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in  input  1  debounced button level from the debouncer; may be asynchronous to clk.
- press  output  1  one-cycle pulse on press.
- short_rel  output  1  one-cycle pulse on release before LONG_CYCLES.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat  output  1  one-cycle auto-repeat pulse while held.
- held  output  1  level, high while in state HELD.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. All flops clear immediately on rst: sync stages 0, state IDLE, counter 0, all outputs 0.
- Synchroniser: `in` passes through 2 flops (s1, s2). The FSM sees only s2.
- Outputs are registered. Latency: `in` first sampled high at edge k; press is high for exactly the cycle after edge k+2. Release latency is the same.
- States (enum): IDLE, PRESSED, HELD.
- IDLE:
  - s2=1 → PRESSED; press=1; cnt←0.
- PRESSED:
  - s2=0 → IDLE; short_rel=1.
  - Otherwise, cnt==LONG_CYCLES-1 → HELD; long_press=1; cnt←0.
  - Otherwise cnt←cnt+1.
  - Release and threshold on the same cycle: release wins (short_rel only, no long_press).
- HELD:
  - s2=0 → IDLE; no short_rel, no other pulse.
  - Otherwise cnt counts for repeat (see Optional Feature); held=1.
- Pulse rules:
  - At most one of press/short_rel/long_press/repeat is high in any cycle.
  - Each pulse is exactly 1 cycle wide.
  - A new press is accepted the cycle after returning to IDLE; there is no lockout.
- Counter: unsigned CNT_W bits; never wraps because it is cleared on every transition.
- Reset mid-press (rst asserted while PRESSED or HELD): no pulse is emitted. After rst deasserts with `in` still high, a fresh press is generated after the sync latency.
- `in` glitch shorter than 1 clk: may be missed. A 1-cycle pulse that reaches s2 produces press then short_rel.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: in HELD, cnt increments each cycle. When cnt==REPEAT_CYCLES-1, repeat=1 and cnt←0. First repeat arrives REPEAT_CYCLES cycles after long_press. Release in the same cycle as a repeat match: release wins, no repeat.
- Undefined: repeat is tied to 0, the HELD counter is not built, and REPEAT_CYCLES is unused.

Decomposition:
- Package button_pkg:
  - typedef enum state_t {IDLE, PRESSED, HELD};
  - default-timing constants shared with the debouncer: clock frequency, long-press and repeat periods.
- One natural sub-module: sync_2ff (2-stage synchroniser, async active-high reset to 0). It is reusable for other asynchronous inputs.
- FSM and counter stay in button_event.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN defined unless noted):
- rst high, in=1 → all outputs 0. rst low at edge 0 → press high during the cycle after edge 2, then 0.
- in high for 5 cycles then low → exactly one press, then one short_rel. No long_press, held stays 0.
- in held for 20 cycles → press; long_press 8 cycles after press; held=1; repeat at +4 and +8 after long_press; release gives no short_rel.
- in released on the exact cycle cnt==7 in PRESSED → short_rel only, long_press never asserted.
- rst pulsed mid-HELD with in still high → outputs 0 immediately. After release of rst, a new press arrives 3 edges later.
- BUTTON_EVENT_REPEAT_EN undefined, in held for 30 cycles → repeat never asserted; long_press exactly once.
